// File: rtl/fib_controller_pkg.sv
// Shared constants for the Fibonacci sequencer: control-word layout and FSM state codes.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package fib_ctrl_pkg;

    // Control-word width; the datapath decodes exactly these five strobes.
    localparam int C_W = 5;

    // Bit positions inside the control word c.
    localparam int C_INIT  = 0;
    localparam int C_ADD   = 1;
    localparam int C_SHIFT = 2;
    localparam int C_DEC   = 3;
    localparam int C_LATCH = 4;

    // State enumeration, kept as plain codes so older tools and dumps read them directly.
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_INIT  = 3'd1;
    localparam state_t S_CHECK = 3'd2;
    localparam state_t S_ADD   = 3'd3;
    localparam state_t S_SHIFT = 3'd4;
    localparam state_t S_DEC   = 3'd5;
    localparam state_t S_DONE  = 3'd6;

    // Moore decode: each working state raises exactly one strobe; IDLE and CHECK raise none.
    function automatic logic [C_W-1:0] ctrl_word(input state_t s);
        logic [C_W-1:0] w;
        w          = '0;
        w[C_INIT]  = (s == S_INIT);
        w[C_ADD]   = (s == S_ADD);
        w[C_SHIFT] = (s == S_SHIFT);
        w[C_DEC]   = (s == S_DEC);
        w[C_LATCH] = (s == S_DONE);
        return w;
    endfunction

endpackage

// File: rtl/fib_controller_if.sv
// Bundle of request/status/control signals between a host+datapath and the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; start is simply ignored while the sequencer is busy.
interface fib_controller_if #(
    parameter int N_W = 8,
    parameter int C_W = 5
) ();
    logic           start;
    logic           abort;
    logic [N_W-1:0] n_in;
    logic           is_n_0;
    logic [C_W-1:0] c;
    logic [N_W-1:0] n;
    logic           busy;
    logic           done;
    logic           err;
    logic [N_W-1:0] iter;

    // Host/datapath side drives requests and status, observes control.
    modport master (
        output start, abort, n_in, is_n_0,
        input  c, n, busy, done, err, iter
    );

    // Sequencer side.
    modport slave (
        input  start, abort, n_in, is_n_0,
        output c, n, busy, done, err, iter
    );
endinterface

// File: rtl/fib_controller_iter_counter.sv
// Iteration counter: cleared on accepted start, +1 per completed DEC, saturating, compared to n.
// Latency: count visible the cycle after the increment edge; eq_n is combinational.
// Backpressure: none; inc/clr are single-cycle strobes from the FSM.
module fib_iter_counter #(
    parameter int N_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           inc,
    input  logic [N_W-1:0] n,
    output logic [N_W-1:0] iter,
    output logic           eq_n
);

    logic [N_W-1:0] cnt;

    // Count DEC cycles; clear wins over increment, and the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {N_W{1'b1}})) begin
            cnt <= cnt + {{(N_W-1){1'b0}}, 1'b1};
        end
    end

    assign iter = cnt;
    assign eq_n = (cnt == n);

endmodule

// File: rtl/fib_controller.sv
// Moore FSM sequencing a Fibonacci datapath: INIT, then (CHECK, ADD, SHIFT, DEC)* until done.
// Latency: done pulses 3+4*n cycles after the start edge.
// Backpressure: start ignored while busy; abort cancels any working state except DONE.
module fib_controller
    import fib_ctrl_pkg::*;
#(
    parameter int N_W = 8,
    parameter int C_W = fib_ctrl_pkg::C_W  // layout is fixed at five strobes
) (
    input  logic           clk,
    input  logic           rst,
    fib_controller_if.slave bus
);

    state_t         state;
    state_t         state_nxt;
    logic [N_W-1:0] n_q;
    logic           err_q;
    logic [N_W-1:0] iter_q;
    logic           iter_eq_n;
    logic           start_acc;
    logic           dec_inc;
    logic           work_st;

    assign start_acc = (state == S_IDLE) && bus.start && !bus.abort;
    assign work_st   = (state == S_INIT) || (state == S_CHECK) || (state == S_ADD) ||
                       (state == S_SHIFT) || (state == S_DEC);
    // An aborted DEC does not count as a completed iteration.
    assign dec_inc   = (state == S_DEC) && !bus.abort;

    // Next-state logic; abort takes priority in every working state.
    always_comb begin
        state_nxt = state;
        if (work_st && bus.abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = start_acc ? S_INIT : S_IDLE;
                S_INIT:  state_nxt = S_CHECK;
                S_CHECK: state_nxt = (bus.is_n_0 || iter_eq_n) ? S_DONE : S_ADD;
                S_ADD:   state_nxt = S_SHIFT;
                S_SHIFT: state_nxt = S_DEC;
                S_DEC:   state_nxt = S_CHECK;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch and sticky error: iterations ran out before the datapath reported zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q   <= '0;
            err_q <= 1'b0;
        end else if (start_acc) begin
            n_q   <= bus.n_in;
            err_q <= 1'b0;
        end else if ((state == S_CHECK) && !bus.abort && !bus.is_n_0 && iter_eq_n) begin
            err_q <= 1'b1;
        end
    end

    fib_iter_counter #(
        .N_W (N_W)
    ) u_iter (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_acc),
        .inc  (dec_inc),
        .n    (n_q),
        .iter (iter_q),
        .eq_n (iter_eq_n)
    );

    assign bus.c    = ctrl_word(state);
    assign bus.n    = n_q;
    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);
    assign bus.err  = err_q;
    assign bus.iter = iter_q;

endmodule

// File: tb/tb_fib_controller.sv
// Bench for fib_controller: directed corner cases plus randomized sequences against a cycle-count model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fib_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   stuck = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    fib_controller_if #(.N_W(8), .C_W(5)) bus ();

    fib_controller #(.N_W(8), .C_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural Fibonacci datapath steered by the control word.
    logic [31:0] dp_a = 0;
    logic [31:0] dp_b = 0;
    logic [31:0] dp_t = 0;
    logic [7:0]  dp_cnt = 0;

    always @(posedge clk) begin
        if (bus.c[0]) begin dp_a <= 0; dp_b <= 1; dp_cnt <= bus.n; end
        if (bus.c[1]) dp_t <= dp_a + dp_b;
        if (bus.c[2]) begin dp_a <= dp_b; dp_b <= dp_t; end
        if (bus.c[3]) dp_cnt <= dp_cnt - 8'd1;
    end

    assign bus.is_n_0 = stuck ? 1'b0 : (dp_cnt == 8'd0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int fib_ref(input int k);
        int a = 0;
        int b = 1;
        int t;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Expected control word in cycle t of a sequence of nv iterations (cycle 1 = INIT).
    function automatic logic [31:0] exp_c(input int t, input int nv);
        if (t == 1) return 32'h01;
        if (t == 3 + 4 * nv) return 32'h10;
        case ((t - 2) % 4)
            0: return 32'h00;
            1: return 32'h02;
            2: return 32'h04;
            default: return 32'h08;
        endcase
    endfunction

    // Completed DEC cycles strictly before cycle a (DEC cycles are 5, 9, 13, ...).
    function automatic int iter_before(input int a);
        if (a < 6) return 0;
        return (a - 2) / 4;
    endfunction

    // One sequence: nv iterations, optional stuck is_n_0, abort in cycle ab_at (0 = none), start held.
    task automatic run_seq(input int nv, input bit stk, input int ab_at, input bit hold);
        int  done_cyc;
        bit  aborted;
        done_cyc = 3 + 4 * nv;
        aborted  = 1'b0;
        @(negedge clk);
        stuck     = stk;
        bus.abort = 1'b0;
        bus.start = 1'b1;
        bus.n_in  = nv[7:0];
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        check("err_clr", bus.err, 0);
        check("n_latch", bus.n, nv);
        check("iter_clr", bus.iter, 0);
        for (int t = 1; t <= done_cyc && !aborted; t++) begin
            if (t > 1) @(negedge clk);
            check("c", bus.c, exp_c(t, nv));
            check("busy", bus.busy, 1);
            check("done", bus.done, (t == done_cyc) ? 1 : 0);
            if (t == ab_at) begin
                bus.abort = 1'b1;
                if (t != done_cyc) begin
                    @(negedge clk);
                    bus.abort = 1'b0;
                    aborted   = 1'b1;
                    check("abort_idle", bus.busy, 0);
                    check("abort_nodone", bus.done, 0);
                    check("abort_iter", bus.iter, iter_before(t));
                    check("abort_n", bus.n, nv);
                end
            end
        end
        if (!aborted) begin
            check("iter_done", bus.iter, nv);
            check("err_done", bus.err, stk);
            check("fib_out", dp_a, fib_ref(nv));
            @(negedge clk);
            bus.abort = 1'b0;
            check("idle_after", bus.busy, 0);
            if (hold) begin
                @(negedge clk);
                check("rehold_init", bus.c, 32'h01);
                bus.start = 1'b0;
                begin
                    bit seen = 1'b0;
                    for (int i = 0; i < 40 && !seen; i++) begin
                        @(negedge clk);
                        if (bus.done) seen = 1'b1;
                    end
                    check("rehold_done", seen, 1);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.n_in  = '0;
        #1;
        check("rst_c", bus.c, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_iter", bus.iter, 0);
        check("rst_n", bus.n, 0);
        @(negedge clk);
        rst = 1'b1;

        run_seq(0, 0, 0, 0);
        run_seq(3, 0, 0, 0);
        run_seq(5, 0, 7, 0);
        run_seq(1, 0, 0, 0);
        run_seq(2, 1, 0, 0);
        run_seq(2, 0, 0, 0);
        run_seq(1, 0, 7, 0);   // abort during DONE is ignored
        run_seq(1, 0, 0, 1);   // start held high through the sequence
        run_seq(0, 1, 0, 0);

        // abort beats start in IDLE
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.n_in  = 8'd3;
        @(negedge clk);
        check("abort_wins", bus.busy, 0);
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // asynchronous reset in the middle of ADD, then immediate retry
        @(negedge clk);
        bus.start = 1'b1;
        bus.n_in  = 8'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_add", bus.c, 32'h02);
        check("pre_rst_iter", bus.iter, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_c", bus.c, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_iter", bus.iter, 0);
        check("arst_done", bus.done, 0);
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.n_in  = 8'd4;
        @(negedge clk);
        bus.start = 1'b0;
        check("retry_init", bus.c, 32'h01);
        begin
            int cyc = 1;
            while (!bus.done && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            check("retry_done_cyc", cyc, 19);
            check("retry_iter", bus.iter, 4);
        end
        @(negedge clk);

        for (int k = 0; k < 20; k++) begin
            int nv;
            bit stk;
            int ab;
            nv  = $urandom_range(0, 10);
            stk = ($urandom_range(0, 3) == 0);
            ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3 + 4 * nv) : 0;
            run_seq(nv, stk, ab, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
